// File: rtl/dram_pkg.sv
// dram_pkg: command encodings, responder states and index widths shared by the DRAM responder.
package dram_pkg;
  localparam logic [1:0] CMD_REFRESH   = 2'b00;
  localparam logic [1:0] CMD_ACTIVATE  = 2'b01;
  localparam logic [1:0] CMD_RW        = 2'b10;
  localparam logic [1:0] CMD_PRECHARGE = 2'b11;
  typedef enum logic [2:0] {
    IDLE, ACT_WAIT, PRE_WAIT, REF_WAIT, WR_SHIFT, RD_SHIFT, ACK, RELEASE
  } state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int BANK_IDX_W = idx_w(8);
  localparam int ROW_IDX_W  = idx_w(128);
  localparam int COL_IDX_W  = idx_w(8);
endpackage

// File: rtl/dram_onehot_encoder.sv
// dram_onehot_encoder: one-hot to index, valid only when exactly one bit is set.
module dram_onehot_encoder
  import dram_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = idx_w(W)
) (
  input  logic [W-1:0]  in_vec,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++)
      if (in_vec[i]) idx = idx | IW'(i);
  end
  assign valid = (in_vec != '0) && ((in_vec & (in_vec - W'(1))) == '0);
endmodule

// File: rtl/dram_bank_responder.sv
// dram_bank_responder: device-side DRAM command responder with per-bank row buffers and serial data.
module dram_bank_responder
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 4,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 16
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic                    buf_rw,
  input  logic                    bank_rw,
  inout  wire                     dram_data,
  output logic                    cmd_ack,
  output logic                    cmd_err,
  output logic                    busy
);
  localparam int BW = idx_w(NUM_OF_BANKS);
  localparam int RW = idx_w(NUM_OF_ROWS);
  localparam int CLW = idx_w(NUM_OF_COLS);
  localparam int TM1 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TM2 = (T_RFC > DATA_WIDTH) ? T_RFC : DATA_WIDTH;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int CW = $clog2(TMAX + 1);
  state_e state_q, state_d;
  logic [BW-1:0] bank_q, bank_d, bank_idx;
  logic [RW-1:0] row_q, row_d, row_idx;
  logic [CLW-1:0] col_q, col_d, col_idx;
  logic bank_v, row_v, col_v, acc_err, done, first;
  logic bank_rw_q, bank_rw_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [NUM_OF_BANKS-1:0] open_q, open_d;
  logic [RW-1:0] open_row_q [NUM_OF_BANKS];
  logic [RW-1:0] open_row_d [NUM_OF_BANKS];
  logic [DATA_WIDTH-1:0] mem_q [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];
  logic [DATA_WIDTH-1:0] rbuf_q [NUM_OF_BANKS][NUM_OF_COLS];
  logic act_load, pre_wb, wr_commit;
  dram_onehot_encoder #(.W(NUM_OF_BANKS)) u_bank (.in_vec(bank_sel), .idx(bank_idx), .valid(bank_v));
  dram_onehot_encoder #(.W(NUM_OF_ROWS))  u_row  (.in_vec(row_sel),  .idx(row_idx),  .valid(row_v));
  dram_onehot_encoder #(.W(NUM_OF_COLS))  u_col  (.in_vec(col_sel),  .idx(col_idx),  .valid(col_v));
  assign acc_err = (cmd == CMD_REFRESH)  ? |open_q :
                   (cmd == CMD_ACTIVATE) ? (!bank_v || !row_v || open_q[bank_idx]) :
                   (cmd == CMD_RW)       ? (!bank_v || !col_v || !open_q[bank_idx]) : !bank_v;
  assign lim = CW'(state_q == ACT_WAIT ? T_RCD : state_q == PRE_WAIT ? T_RP :
                   state_q == REF_WAIT ? T_RFC : DATA_WIDTH);
  assign done = cnt_q == lim;
  assign first = cnt_q == CW'(1);
  assign act_load = state_q == ACT_WAIT && first;
  assign pre_wb = state_q == PRE_WAIT && first && bank_rw_q && open_q[bank_q];
  assign wr_commit = state_q == WR_SHIFT && done;
  always_comb begin
    state_d = state_q;
    bank_d = bank_q;
    row_d = row_q;
    col_d = col_q;
    bank_rw_d = bank_rw_q;
    err_d = err_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    open_d = open_q;
    open_row_d = open_row_q;
    case (state_q)
      IDLE: if (cmd_req) begin
        bank_d = bank_idx;
        row_d = row_idx;
        col_d = col_idx;
        bank_rw_d = bank_rw;
        err_d = acc_err;
        cnt_d = CW'(1);
        sr_d = rbuf_q[bank_idx][col_idx];
        state_d = acc_err ? ACK : cmd == CMD_ACTIVATE ? ACT_WAIT : cmd == CMD_PRECHARGE ? PRE_WAIT :
                  cmd == CMD_REFRESH ? REF_WAIT : buf_rw ? WR_SHIFT : RD_SHIFT;
      end
      ACK: state_d = RELEASE;
      RELEASE: state_d = cmd_req ? RELEASE : IDLE;
      default: begin
        cnt_d = done ? cnt_q : cnt_q + CW'(1);
        state_d = done ? ACK : state_q;
      end
    endcase
    if (act_load) begin
      open_d[bank_q] = 1'b1;
      open_row_d[bank_q] = row_q;
    end
    if (state_q == PRE_WAIT && first) open_d[bank_q] = 1'b0;
    if (state_q == WR_SHIFT) sr_d = {dram_data, sr_q[DATA_WIDTH-1:1]};
    if (state_q == RD_SHIFT) sr_d = sr_q >> 1;
  end
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      open_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      open_q <= open_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      bank_q <= bank_d;
      row_q <= row_d;
      col_q <= col_d;
      bank_rw_q <= bank_rw_d;
      sr_q <= sr_d;
      open_row_q <= open_row_d;
    end
  end
  // Storage is never cleared; reset only suppresses pending updates.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int c = 0; c < NUM_OF_COLS; c++) begin
        if (act_load) rbuf_q[bank_q][c] <= mem_q[bank_q][row_q][c];
        if (pre_wb) mem_q[bank_q][open_row_q[bank_q]][c] <= rbuf_q[bank_q][c];
      end
      if (wr_commit) rbuf_q[bank_q][col_q] <= sr_d;
    end
  end
  assign dram_data = (state_q == RD_SHIFT) ? sr_q[0] : 1'bz;
  assign cmd_ack = state_q == ACK;
  assign cmd_err = cmd_ack && err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_dram_bank_responder.sv
// tb_dram_bank_responder: directed bench with a bank/row-buffer reference model and per-cycle compare.
module tb_dram_bank_responder;
  import dram_pkg::*;
  localparam int DW = 8, TRCD = 4, TRP = 3, TRFC = 16;
  logic clk = 1'b0, rst_b = 1'b1, cmd_req = 1'b0, buf_rw = 1'b0, bank_rw = 1'b0;
  logic [1:0] cmd = '0;
  logic [7:0] bank_sel = '0, col_sel = '0;
  logic [127:0] row_sel = '0;
  logic cmd_ack, cmd_err, busy;
  wire dram_data;
  logic tb_oe = 1'b0, tb_bit = 1'b0;
  assign dram_data = tb_oe ? tb_bit : 1'bz;
  dram_bank_responder dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd), .bank_sel(bank_sel),
    .row_sel(row_sel), .col_sel(col_sel), .buf_rw(buf_rw), .bank_rw(bank_rw),
    .dram_data(dram_data), .cmd_ack(cmd_ack), .cmd_err(cmd_err), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, n_ack = 0;
  logic chk_en = 1'b0, exp_ack = 1'b0, exp_busy = 1'b0, exp_err = 1'b0, exp_drv = 1'b0, exp_bit = 1'b0;
  logic [7:0] m_mem [8][128][8];
  bit m_memk [8][128][8];
  logic [7:0] m_rb [8][8];
  bit m_rbk [8][8];
  logic [7:0] m_open = '0;
  int m_orow [8];
  int a_cyc;
  logic [7:0] rd_w;
  logic e_exp;
  localparam logic [127:0] R5 = 128'd1 << 5;
  localparam logic [127:0] R100 = 128'd1 << 100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("ack", cmd_ack, exp_ack);
    chk("busy", busy, exp_busy);
    chk("err", cmd_err, exp_err);
    if (exp_drv) chk("rd_bit", dram_data, exp_bit);
    if (cmd_ack) n_ack++;
  end

  task automatic run(input logic [1:0] c, input logic [7:0] bs, input logic [127:0] rs,
                     input logic [7:0] cs, input logic brw, input logic bkrw,
                     input logic [7:0] wd, input int hold, input int rk);
    int b, r, co, lat;
    logic e, aborted;
    logic [7:0] word;
    bit kn;
    b = oh_idx(128'(bs));
    r = oh_idx(rs);
    co = oh_idx(128'(cs));
    e = (c == CMD_REFRESH)  ? |m_open :
        (c == CMD_ACTIVATE) ? ($countones(bs) != 1 || $countones(rs) != 1 || m_open[b]) :
        (c == CMD_RW)       ? ($countones(bs) != 1 || $countones(cs) != 1 || !m_open[b]) :
                              ($countones(bs) != 1);
    lat = e ? 1 : c == CMD_ACTIVATE ? TRCD + 1 : c == CMD_PRECHARGE ? TRP + 1 :
          c == CMD_REFRESH ? TRFC + 1 : DW + 1;
    word = m_rb[b][co];
    kn = m_rbk[b][co];
    e_exp = e;
    aborted = 1'b0;
    a_cyc = 0;
    rd_w = '0;
    cmd_req = 1'b1; cmd = c; bank_sel = bs; row_sel = rs; col_sel = cs; buf_rw = brw; bank_rw = bkrw;
    @(posedge clk); #1;
    for (int k = 1; k <= lat + hold + 1; k++) begin
      if (k == rk) rst_b = 1'b1;
      exp_busy = 1'b1;
      exp_ack = (k == lat);
      exp_err = (k == lat) && e;
      exp_drv = (c == CMD_RW) && !brw && !e && k <= DW && kn;
      exp_bit = word[(k-1)%8];
      tb_oe = (c == CMD_RW) && brw && !e && k <= DW;
      tb_bit = wd[(k-1)%8];
      cmd_req = (k <= lat + hold);
      cmd = 2'($urandom); bank_sel = 8'($urandom); row_sel = {4{$urandom}}; col_sel = 8'($urandom);
      buf_rw = 1'($urandom); bank_rw = 1'($urandom);
      if (cmd_ack && a_cyc == 0) a_cyc = k;
      if (k <= DW) rd_w[k-1] = dram_data;
      @(posedge clk); #1;
      if (k == rk) begin
        rst_b = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    tb_oe = 1'b0; cmd_req = 1'b0;
    exp_busy = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_drv = 1'b0;
    if (aborted) m_open = '0;
    else if (!e) begin
      if (c == CMD_ACTIVATE) begin
        m_open[b] = 1'b1;
        m_orow[b] = r;
        for (int i = 0; i < 8; i++) begin
          m_rb[b][i] = m_mem[b][r][i];
          m_rbk[b][i] = m_memk[b][r][i];
        end
      end else if (c == CMD_PRECHARGE) begin
        if (bkrw && m_open[b])
          for (int i = 0; i < 8; i++) begin
            m_mem[b][m_orow[b]][i] = m_rb[b][i];
            m_memk[b][m_orow[b]][i] = m_rbk[b][i];
          end
        m_open[b] = 1'b0;
      end else if (c == CMD_RW && brw) begin
        m_rb[b][co] = wd;
        m_rbk[b][co] = 1'b1;
      end
    end
  endtask

  task automatic act(input logic [7:0] bs, input logic [127:0] rs);
    run(CMD_ACTIVATE, bs, rs, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask
  task automatic wr(input logic [7:0] bs, input logic [7:0] cs, input logic [7:0] wd);
    run(CMD_RW, bs, '0, cs, 1'b1, 1'b0, wd, 0, 0);
  endtask
  task automatic rd(input logic [7:0] bs, input logic [7:0] cs);
    run(CMD_RW, bs, '0, cs, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask
  task automatic pre(input logic [7:0] bs, input logic bkrw);
    run(CMD_PRECHARGE, bs, '0, 8'h00, 1'b0, bkrw, 8'h00, 0, 0);
  endtask

  initial begin
    int n0;
    for (int b = 0; b < 8; b++) for (int c = 0; c < 8; c++) m_rbk[b][c] = 1'b0;
    for (int b = 0; b < 8; b++) for (int r = 0; r < 128; r++) for (int c = 0; c < 8; c++) m_memk[b][r][c] = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    chk("reset_busy", busy, 0);
    act(8'h04, R5);
    chk("act_lat", a_cyc, 5); chk("act_err", e_exp, 0);
    wr(8'h04, 8'h08, 8'hA5);
    chk("wr_lat", a_cyc, 9);
    rd(8'h04, 8'h08);
    chk("rd_lat", a_cyc, 9); chk("rd_a5", rd_w, 8'hA5);
    pre(8'h04, 1'b1);
    chk("pre_lat", a_cyc, 4);
    act(8'h04, R5);
    rd(8'h04, 8'h08);
    chk("wb_keep", rd_w, 8'hA5);
    wr(8'h04, 8'h08, 8'h3C);
    rd(8'h04, 8'h08);
    chk("rd_3c", rd_w, 8'h3C);
    pre(8'h04, 1'b0);
    act(8'h04, R5);
    rd(8'h04, 8'h08);
    chk("discard", rd_w, 8'hA5);
    rd(8'h01, 8'h08);
    chk("closed_err", e_exp, 1); chk("closed_lat", a_cyc, 1);
    act(8'h06, R5);
    chk("multihot_err", e_exp, 1); chk("multihot_lat", a_cyc, 1);
    run(CMD_REFRESH, 8'h00, '0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
    chk("ref_open_err", e_exp, 1); chk("ref_open_lat", a_cyc, 1);
    rd(8'h04, 8'h08);
    chk("still_open", rd_w, 8'hA5); chk("still_open_err", e_exp, 0);
    n0 = n_ack;
    run(CMD_RW, 8'h04, '0, 8'h08, 1'b0, 1'b0, 8'h00, 5, 0);
    chk("hold_lat", a_cyc, 9); chk("hold_one_ack", n_ack - n0, 1);
    act(8'h20, R100);
    chk("next_accept_lat", a_cyc, 5);
    wr(8'h20, 8'h01, 8'h77);
    rd(8'h20, 8'h01);
    chk("bank5_rd", rd_w, 8'h77);
    rd(8'h04, 8'h08);
    chk("bank2_rd", rd_w, 8'hA5);
    pre(8'h80, 1'b1);
    chk("pre_closed_err", e_exp, 0); chk("pre_closed_lat", a_cyc, 4);
    pre(8'h20, 1'b1);
    pre(8'h04, 1'b1);
    run(CMD_REFRESH, 8'h00, '0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
    chk("ref_lat", a_cyc, 17); chk("ref_err", e_exp, 0);
    act(8'h04, R5);
    run(CMD_RW, 8'h04, '0, 8'h08, 1'b1, 1'b0, 8'h5A, 0, 4);
    chk("abort_no_ack", a_cyc, 0);
    rd(8'h04, 8'h08);
    chk("abort_closed", e_exp, 1);
    act(8'h04, R5);
    rd(8'h04, 8'h08);
    chk("abort_prewrite", rd_w, 8'hA5);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
